// File: rtl/cod_16_4_2_sync_if.sv
// Request/index bus for the 16-to-4 registered priority encoder.
// The request source drives A.
// The encoder returns the index Y and the valid flag V.
interface cod_16_4_2_sync_if;
  logic [15:0] A;  // request vector, bit 15 is the highest priority
  logic [3:0]  Y;  // index of the highest set bit (registered)
  logic        V;  // at least one request bit was set (registered)

  // Request source: drives A and observes the encoded result.
  modport master (
    output A,
    input  Y,
    input  V
  );

  // Encoder: samples A and drives the registered result.
  modport slave (
    input  A,
    output Y,
    output V
  );
endinterface

// File: rtl/cod_16_4_2_sync.sv
// Registered 16-to-4 priority encoder.
// Y carries the index of the most significant set bit of A.
// V flags that A was non-zero, so A=16'h0001 can be told apart from A=16'h0000.
// Latency is one clock.
module cod_16_4_2_sync (
  input  logic               clk,
  input  logic               rst_n,
  cod_16_4_2_sync_if.slave   bus
);

  logic [3:0] idx;
  logic       any;
  logic [3:0] y_d, y_q;
  logic       v_d, v_q;

  // Combinational core: find the highest asserted request bit.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write.
    // A path that leaves a variable unassigned would infer a latch.
    idx = 4'd0;
    any = 1'b0;
    // The scan runs upward, so a later (higher) set bit overrides a lower one.
    // The highest index therefore wins.
    for (int i = 0; i < 16; i++) begin
      if (bus.A[i]) begin
        idx = 4'(i);
        any = 1'b1;
      end
    end
    y_d = any ? idx : 4'd0;
    v_d = any;
  end

  // Output register: clears asynchronously on reset.
  // Otherwise it captures the encoding on every rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments.
    // All flops then update together from the values that existed before the edge.
    if (!rst_n) begin
      y_q <= 4'd0;
      v_q <= 1'b0;
    end else begin
      y_q <= y_d;
      v_q <= v_d;
    end
  end

  assign bus.Y = y_q;
  assign bus.V = v_q;

endmodule

// File: tb/tb_cod_16_4_2_sync.sv
// Self-checking bench for cod_16_4_2_sync.
// Each driven request vector pushes its expected result onto a scoreboard queue.
// The entry is popped and compared when the registered output appears one edge later.
module tb_cod_16_4_2_sync;

  typedef struct packed {
    logic [3:0] y;
    logic       v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  cod_16_4_2_sync_if bus ();

  cod_16_4_2_sync dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  // Reference model: scans downward from bit 15 and stops at the first set bit.
  function automatic exp_t model(input logic [15:0] a);
    exp_t e;
    e.y = 4'd0;
    e.v = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (a[i] && !e.v) begin
        e.y = 4'(i);
        e.v = 1'b1;
      end
    end
    return e;
  endfunction

  // Pops the oldest expectation and compares it with the DUT output.
  task automatic compare(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 16'd0, 16'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_Y"}, {12'd0, bus.Y}, {12'd0, e.y});
      check({tag, "_V"}, {15'd0, bus.V}, {15'd0, e.v});
    end
  endtask

  // Drives A between edges, records the expectation, and checks it after the next edge.
  task automatic drive(input logic [15:0] a);
    @(negedge clk);
    bus.A = a;
    sb_q.push_back(model(a));
    @(posedge clk);
    #1;
    compare($sformatf("A_%04h", a));
  endtask

  initial begin
    logic [15:0] multi [4];
    n_checks = 0;
    n_fail   = 0;
    multi[0] = 16'b01000000_00000100;
    multi[1] = 16'b00001001_00000000;
    multi[2] = 16'b00000000_01010000;
    multi[3] = 16'b00000000_00000011;

    // Reset with all requests set: the outputs must stay cleared.
    rst_n  = 1'b0;
    bus.A  = 16'hFFFF;
    #2;
    check("rst_Y", {12'd0, bus.Y}, 16'd0);
    check("rst_V", {15'd0, bus.V}, 16'd0);
    @(posedge clk);
    #1;
    check("rst_hold_Y", {12'd0, bus.Y}, 16'd0);
    check("rst_hold_V", {15'd0, bus.V}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(16'hFFFF);

    // Walking one from bit 15 down to bit 0.
    for (int i = 15; i >= 0; i--) drive(16'h0001 << i);

    // Multi-bit priority patterns.
    for (int i = 0; i < 4; i++) drive(multi[i]);

    // Zero versus bit 0.
    drive(16'h0000);
    drive(16'h0001);

    // A few random vectors.
    for (int i = 0; i < 8; i++) drive(16'($urandom));

    // Latency: a change between edges must not reach Y until the next edge.
    drive(16'h0010);
    @(negedge clk);
    bus.A = 16'h0400;
    sb_q.push_back(model(16'h0400));
    #1;
    check("lat_hold_Y", {12'd0, bus.Y}, 16'd4);
    check("lat_hold_V", {15'd0, bus.V}, 16'd1);
    @(posedge clk);
    #1;
    compare("lat_A_0400");

    // Mid-run reset while A=16'h2000 streams.
    drive(16'h2000);
    drive(16'h2000);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_Y", {12'd0, bus.Y}, 16'd0);
    check("midrst_V", {15'd0, bus.V}, 16'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(model(bus.A));
    @(posedge clk);
    #1;
    compare("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
